// File: rtl/ppc_inst_queue.sv
// Circular instruction queue between fetch and multi-issue decode: FETCH_N-wide push, 0..ISSUE_N pop.
// Optional IQ_STATS_EN macro enables saturating stall/issue counters; without it both read as zero.
module ppc_inst_queue #(
  parameter int DEPTH   = 64,
  parameter int INST_W  = 32,
  parameter int PC_W    = 64,
  parameter int FETCH_N = 2,
  parameter int ISSUE_N = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_valid,
  output logic                         fetch_ready,
  input  logic [FETCH_N*INST_W-1:0]    fetch_data,
  input  logic [PC_W-1:0]              fetch_pc,
  input  logic                         flush,
  input  logic [$clog2(ISSUE_N+1)-1:0] pop_count,
  output logic [ISSUE_N-1:0]           out_valid,
  output logic [ISSUE_N*INST_W-1:0]    out_inst,
  output logic [ISSUE_N*PC_W-1:0]      out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic [31:0]                  stat_stall,
  output logic [31:0]                  stat_issued
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [INST_W-1:0] mem_inst_q [DEPTH];
  logic [PC_W-1:0]   mem_pc_q   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] eff_pop;
  logic             push;

  // Readiness looks only at the registered count, so slots freed this cycle are not reused yet.
  assign fetch_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_N);
  assign push        = fetch_valid & fetch_ready & ~flush;
  assign eff_pop     = (CNT_W'(pop_count) > count_q) ? count_q : CNT_W'(pop_count);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    head_d  = head_q + PTR_W'(eff_pop);
    tail_d  = tail_q;
    count_d = count_q - eff_pop;
    if (push) begin
      tail_d  = tail_q + PTR_W'(FETCH_N);
      count_d = count_q - eff_pop + CNT_W'(FETCH_N);
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the entry array is deliberately not reset; stale entries are masked at the output instead.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < FETCH_N; k++) begin
        mem_inst_q[tail_q + PTR_W'(k)] <= fetch_data[k*INST_W +: INST_W];
        mem_pc_q[tail_q + PTR_W'(k)]   <= fetch_pc + PC_W'(4*k);
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int i = 0; i < ISSUE_N; i++) begin
      if (count_q > CNT_W'(i)) begin
        out_valid[i]                 = 1'b1;
        out_inst[i*INST_W +: INST_W] = mem_inst_q[head_q + PTR_W'(i)];
        out_pc[i*PC_W +: PC_W]       = mem_pc_q[head_q + PTR_W'(i)];
      end
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);

`ifdef IQ_STATS_EN
  logic [31:0] stall_q, issued_q;
  logic [32:0] issued_sum;

  assign issued_sum = {1'b0, issued_q} + 33'(eff_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      issued_q <= '0;
    end else if (!flush) begin
      if (fetch_valid && !fetch_ready && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
      issued_q <= issued_sum[32] ? 32'hFFFF_FFFF : issued_sum[31:0];
    end
  end

  assign stat_stall  = stall_q;
  assign stat_issued = issued_q;
`else
  assign stat_stall  = '0;
  assign stat_issued = '0;
`endif

endmodule

// File: tb/tb_ppc_inst_queue.sv
// Randomised bench for ppc_inst_queue against a queue-based reference model, plus directed literal checks.
module tb_ppc_inst_queue;

  localparam int DEPTH   = 64;
  localparam int INST_W  = 32;
  localparam int PC_W    = 64;
  localparam int FETCH_N = 2;
  localparam int ISSUE_N = 2;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         fetch_valid;
  logic                         fetch_ready;
  logic [FETCH_N*INST_W-1:0]    fetch_data;
  logic [PC_W-1:0]              fetch_pc;
  logic                         flush;
  logic [$clog2(ISSUE_N+1)-1:0] pop_count;
  logic [ISSUE_N-1:0]           out_valid;
  logic [ISSUE_N*INST_W-1:0]    out_inst;
  logic [ISSUE_N*PC_W-1:0]      out_pc;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         empty;
  logic [31:0]                  stat_stall;
  logic [31:0]                  stat_issued;

  ppc_inst_queue #(
    .DEPTH(DEPTH), .INST_W(INST_W), .PC_W(PC_W), .FETCH_N(FETCH_N), .ISSUE_N(ISSUE_N)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .fetch_pc(fetch_pc),
    .flush(flush), .pop_count(pop_count),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .count(count), .empty(empty),
    .stat_stall(stat_stall), .stat_issued(stat_issued)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents as plain queues, oldest at index 0.
  logic [INST_W-1:0] m_inst[$];
  logic [PC_W-1:0]   m_pc[$];
  logic [31:0]       m_stall;
  logic [31:0]       m_issued;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inst.delete();
    m_pc.delete();
    m_stall  = '0;
    m_issued = '0;
  endtask

  task automatic model_step(input bit fv, input logic [FETCH_N*INST_W-1:0] data,
                            input logic [PC_W-1:0] pc, input bit fl, input int pop);
    int  sz;
    int  eff;
    bit  rdy;
    sz  = m_inst.size();
    rdy = (DEPTH - sz) >= FETCH_N;
    eff = (pop < sz) ? pop : sz;
    if (fl) begin
      m_inst.delete();
      m_pc.delete();
    end else begin
      for (int i = 0; i < eff; i++) begin
        void'(m_inst.pop_front());
        void'(m_pc.pop_front());
      end
      if (fv && rdy) begin
        for (int k = 0; k < FETCH_N; k++) begin
          m_inst.push_back(data[k*INST_W +: INST_W]);
          m_pc.push_back(pc + 64'(4*k));
        end
      end
`ifdef IQ_STATS_EN
      if (fv && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if ({1'b0, m_issued} + 33'(eff) > 33'h0_FFFF_FFFF) m_issued = 32'hFFFF_FFFF;
      else m_issued = m_issued + 32'(eff);
`endif
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, return 1 ns after it.
  task automatic cycle(input bit fv, input logic [FETCH_N*INST_W-1:0] data,
                       input logic [PC_W-1:0] pc, input bit fl, input int pop);
    fetch_valid = fv;
    fetch_data  = data;
    fetch_pc    = pc;
    flush       = fl;
    pop_count   = 2'(pop);
    @(posedge clk);
    model_step(fv, data, pc, fl, pop);
    #1;
  endtask

  // Single compare process: every falling edge out of reset, DUT against model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      logic [ISSUE_N-1:0]        e_valid;
      logic [ISSUE_N*INST_W-1:0] e_inst;
      logic [ISSUE_N*PC_W-1:0]   e_pc;
      int sz;
      sz      = m_inst.size();
      e_valid = '0;
      e_inst  = '0;
      e_pc    = '0;
      for (int i = 0; i < ISSUE_N; i++) begin
        if (i < sz) begin
          e_valid[i]                 = 1'b1;
          e_inst[i*INST_W +: INST_W] = m_inst[i];
          e_pc[i*PC_W +: PC_W]       = m_pc[i];
        end
      end
      check("count",       128'(count),       128'(sz));
      check("empty",       128'(empty),       128'(sz == 0));
      check("fetch_ready", 128'(fetch_ready), 128'((DEPTH - sz) >= FETCH_N));
      check("out_valid",   128'(out_valid),   128'(e_valid));
      check("out_inst",    128'(out_inst),    128'(e_inst));
      check("out_pc",      128'(out_pc),      e_pc);
      check("stat_stall",  128'(stat_stall),  128'(m_stall));
      check("stat_issued", 128'(stat_issued), 128'(m_issued));
    end
  end

  function automatic logic [FETCH_N*INST_W-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [31:0] exp_stall;
    logic [31:0] exp_issued;
    rst_n       = 1'b0;
    fetch_valid = 1'b0;
    fetch_data  = '0;
    fetch_pc    = '0;
    flush       = 1'b0;
    pop_count   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_count",       128'(count),       128'd0);
    check("rst_empty",       128'(empty),       128'd1);
    check("rst_fetch_ready", 128'(fetch_ready), 128'd1);
    check("rst_out_valid",   128'(out_valid),   128'd0);
    check("rst_out_inst",    128'(out_inst),    128'd0);
    chk_en = 1'b1;

    // Fill: one beat, visible next cycle.
    cycle(1'b1, {32'hBBBB_0001, 32'hAAAA_0000}, 64'h100, 1'b0, 0);
    check("fill_count",    128'(count),     128'd2);
    check("fill_out_inst", 128'(out_inst),  128'h0000_0000_0000_0000_BBBB_0001_AAAA_0000);
    check("fill_out_pc",   128'(out_pc),    {64'h104, 64'h100});
    check("fill_valid",    128'(out_valid), 128'b11);

    // Full: 32 beats from empty, then a held beat stalls for three cycles.
    cycle(1'b0, '0, '0, 1'b1, 0);
    for (int b = 0; b < DEPTH / FETCH_N; b++)
      cycle(1'b1, rnd_data(), 64'h1000 + 64'(8*b), 1'b0, 0);
    check("full_count", 128'(count),       128'd64);
    check("full_ready", 128'(fetch_ready), 128'd0);
    repeat (3) cycle(1'b1, rnd_data(), 64'h2000, 1'b0, 0);
    check("full_hold_count", 128'(count), 128'd64);
`ifdef IQ_STATS_EN
    exp_stall = 32'd3;
`else
    exp_stall = 32'd0;
`endif
    check("full_stat_stall", 128'(stat_stall), 128'(exp_stall));

    // Clamp: count=1 with pop_count=2 empties without wrapping.
    cycle(1'b0, '0, '0, 1'b1, 0);
    cycle(1'b1, rnd_data(), 64'h3000, 1'b0, 0);
    cycle(1'b0, '0, '0, 1'b0, 1);
    check("clamp_pre_count", 128'(count), 128'd1);
    cycle(1'b0, '0, '0, 1'b0, 2);
    check("clamp_count", 128'(count),     128'd0);
    check("clamp_valid", 128'(out_valid), 128'd0);
    check("clamp_empty", 128'(empty),     128'd1);
`ifdef IQ_STATS_EN
    exp_issued = 32'd2;
`else
    exp_issued = 32'd0;
`endif
    check("clamp_stat_issued", 128'(stat_issued), 128'(exp_issued));

    // Flush at count=10 together with push and pop.
    repeat (5) cycle(1'b1, rnd_data(), 64'h5000, 1'b0, 0);
    check("flush_pre_count", 128'(count), 128'd10);
    cycle(1'b1, rnd_data(), 64'h6000, 1'b1, 1);
    check("flush_count", 128'(count), 128'd0);
    check("flush_empty", 128'(empty), 128'd1);
    cycle(1'b1, {32'h2222_2222, 32'h1111_1111}, 64'h4000, 1'b0, 0);
    check("flush_next_inst", 128'(out_inst), 128'h0000_0000_0000_0000_2222_2222_1111_1111);
    check("flush_next_pc",   128'(out_pc),   {64'h4004, 64'h4000});

    // Wrap: push 2 / pop 2 for 100 cycles keeps count at 2 across the pointer wrap.
    cycle(1'b0, '0, '0, 1'b1, 0);
    cycle(1'b1, rnd_data(), 64'h8000, 1'b0, 0);
    for (int j = 0; j < 100; j++) begin
      cycle(1'b1, rnd_data(), 64'h8000 + 64'(8*(j+1)), 1'b0, 2);
      check("wrap_count", 128'(count), 128'd2);
      check("wrap_pc_step", 128'(out_pc[2*PC_W-1:PC_W] - out_pc[PC_W-1:0]), 128'd4);
    end

    // Random traffic in alternating fill-biased and drain-biased phases.
    for (int n = 0; n < 3000; n++) begin
      int pmax;
      pmax = ((n / 300) % 2 == 0) ? 1 : ISSUE_N;
      cycle($urandom_range(0, 9) < 7, rnd_data(), {$urandom, $urandom},
            $urandom_range(0, 99) < 2, int'($urandom_range(0, pmax)));
    end

    // Asynchronous reset mid-traffic with count=6.
    cycle(1'b0, '0, '0, 1'b1, 0);
    repeat (3) cycle(1'b1, rnd_data(), 64'h9000, 1'b0, 0);
    check("t1_pre_count", 128'(count), 128'd6);
    fetch_valid = 1'b1;
    pop_count   = 2'd1;
    #2 rst_n = 1'b0;
    #1;
    check("t1_count",       128'(count),       128'd0);
    check("t1_empty",       128'(empty),       128'd1);
    check("t1_fetch_ready", 128'(fetch_ready), 128'd1);
    check("t1_out_valid",   128'(out_valid),   128'd0);
    check("t1_stat_stall",  128'(stat_stall),  128'd0);
    model_reset();
    fetch_valid = 1'b0;
    pop_count   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int n = 0; n < 300; n++)
      cycle($urandom_range(0, 9) < 6, rnd_data(), {$urandom, $urandom},
            $urandom_range(0, 99) < 2, int'($urandom_range(0, ISSUE_N)));

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
